// File: rtl/data_memory_dump_unit_pkg.sv
// Shared definitions for the debug data-memory dump: FSM encoding, byte
// geometry and the byte-counter width helper.
package data_memory_dump_unit_pkg;

   localparam int NB_BYTE        = 8;
   localparam int DEF_NB_ADDR    = 5;
   localparam int DEF_NB_DATA    = 32;
   localparam int BYTES_PER_WORD = DEF_NB_DATA / NB_BYTE;

   // Counter width that stays legal when a word holds a single byte.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int NB_BYTE_CNT = cnt_width(BYTES_PER_WORD);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_READ  = 3'd1;
   localparam logic [2:0] S_LATCH = 3'd2;
   localparam logic [2:0] S_SEND  = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE  = S_IDLE,
      ST_READ  = S_READ,
      ST_LATCH = S_LATCH,
      ST_SEND  = S_SEND,
      ST_DONE  = S_DONE
   } dump_state_e;

endpackage

// File: rtl/data_memory_dump_unit_if.sv
// Memory read port and byte-stream (valid/ready) port of the dump unit.
// master = dump unit, slave = memory + UART transmitter side.
interface data_memory_dump_unit_if #(
   parameter int NB_ADDR = 5,
   parameter int NB_DATA = 32
);
   logic [NB_ADDR-1:0] o_mem_rd_addr;
   logic               o_mem_rd_enable;
   logic [NB_DATA-1:0] i_mem_data;
   logic [7:0]         o_tx_data;
   logic               o_tx_valid;
   logic               i_tx_ready;

   modport master (
      output o_mem_rd_addr, o_mem_rd_enable, o_tx_data, o_tx_valid,
      input  i_mem_data, i_tx_ready
   );

   modport slave (
      input  o_mem_rd_addr, o_mem_rd_enable, o_tx_data, o_tx_valid,
      output i_mem_data, i_tx_ready
   );
endinterface

// File: rtl/data_memory_dump_unit_word_byte_serializer.sv
// Splits one memory word into bytes, MSB first, over a valid/ready handshake.
// The byte on o_tx_data comes straight from the shift register, never from ready.
module word_byte_serializer
   import data_memory_dump_unit_pkg::*;
#(
   parameter int NB_DATA = 32
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic               i_load,
   input  logic [NB_DATA-1:0] i_word,
   input  logic               i_tx_ready,
   output logic [7:0]         o_tx_data,
   output logic               o_tx_valid,
   output logic               o_last_accepted
);
   localparam int BPW    = NB_DATA / NB_BYTE;
   localparam int NB_CNT = cnt_width(BPW);
   localparam logic [NB_CNT-1:0] LAST_BYTE = NB_CNT'(BPW - 1);

   logic [NB_DATA-1:0] shift_r;
   logic [NB_CNT-1:0]  byte_cnt_r;
   logic               valid_r;
   logic               accept_s;

   assign accept_s        = valid_r & i_tx_ready;
   assign o_last_accepted = accept_s & (byte_cnt_r == LAST_BYTE);
   assign o_tx_data       = shift_r[NB_DATA-1 -: NB_BYTE];
   assign o_tx_valid      = valid_r;

   // Valid is raised by a load and held until the final byte is taken.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         shift_r    <= '0;
         byte_cnt_r <= '0;
         valid_r    <= 1'b0;
      end else if (i_load) begin
         shift_r    <= i_word;
         byte_cnt_r <= '0;
         valid_r    <= 1'b1;
      end else if (accept_s) begin
         shift_r    <= shift_r << NB_BYTE;
         byte_cnt_r <= byte_cnt_r + NB_CNT'(1);
         valid_r    <= ~o_last_accepted;
      end else begin
         shift_r    <= shift_r;
         byte_cnt_r <= byte_cnt_r;
         valid_r    <= valid_r;
      end
   end

endmodule

// File: rtl/data_memory_dump_unit.sv
// Debug dump of the whole data memory: reads every word in address order and
// streams it out as bytes to the UART transmitter.
module data_memory_dump_unit
   import data_memory_dump_unit_pkg::*;
#(
   parameter int NB_ADDR = DEF_NB_ADDR,
   parameter int NB_DATA = DEF_NB_DATA
) (
   input  logic                    i_clock,
   input  logic                    i_reset,
   input  logic                    i_start,
   output logic                    o_busy,
   output logic                    o_done,
   data_memory_dump_unit_if.master bus
);
   localparam logic [NB_ADDR-1:0] LAST_ADDR = {NB_ADDR{1'b1}};

   dump_state_e        state_r;
   dump_state_e        next_s;
   logic [NB_ADDR-1:0] addr_r;
   logic               busy_r;
   logic               addr_clr_s;
   logic               addr_inc_s;
   logic               load_s;
   logic               last_accepted_s;

   word_byte_serializer #(.NB_DATA(NB_DATA)) u_serializer (
      .i_clock         (i_clock),
      .i_reset         (i_reset),
      .i_load          (load_s),
      .i_word          (bus.i_mem_data),
      .i_tx_ready      (bus.i_tx_ready),
      .o_tx_data       (bus.o_tx_data),
      .o_tx_valid      (bus.o_tx_valid),
      .o_last_accepted (last_accepted_s)
   );

   // State, address counter and the registered busy flag.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         state_r <= ST_IDLE;
         addr_r  <= '0;
         busy_r  <= 1'b0;
      end else begin
         state_r <= next_s;
         busy_r  <= (next_s != ST_IDLE);
         if (addr_clr_s) begin
            addr_r <= '0;
         end else if (addr_inc_s) begin
            addr_r <= addr_r + NB_ADDR'(1);
         end else begin
            addr_r <= addr_r;
         end
      end
   end

   // Termination compares against the all-ones address so the counter never wraps.
   always_comb begin
      next_s     = state_r;
      addr_clr_s = 1'b0;
      addr_inc_s = 1'b0;
      load_s     = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (i_start) begin
               addr_clr_s = 1'b1;
               next_s     = ST_READ;
            end else begin
               next_s = ST_IDLE;
            end
         end
         ST_READ:  next_s = ST_LATCH;
         ST_LATCH: begin
            load_s = 1'b1;
            next_s = ST_SEND;
         end
         ST_SEND: begin
            if (last_accepted_s) begin
               if (addr_r == LAST_ADDR) begin
                  next_s = ST_DONE;
               end else begin
                  addr_inc_s = 1'b1;
                  next_s     = ST_READ;
               end
            end else begin
               next_s = ST_SEND;
            end
         end
         ST_DONE:  next_s = ST_IDLE;
         default:  next_s = ST_IDLE;
      endcase
   end

   assign bus.o_mem_rd_enable = (state_r == ST_READ);
   assign bus.o_mem_rd_addr   = addr_r;
   assign o_done              = (state_r == ST_DONE);
   assign o_busy              = busy_r;

endmodule

// File: tb/tb_data_memory_dump_unit.sv
// Scoreboard bench for data_memory_dump_unit: expected bytes are queued per
// dump, a negedge monitor pops and compares each accepted byte.
module tb_data_memory_dump_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        busy;
   logic        done;
   logic        ready_drv = 1'b0;
   logic [31:0] mem_q = 32'h0;
   logic [31:0] mem [0:31];
   int          mode = 0;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [7:0]  exp_q[$];
   int          nacc = 0;
   int          rd_cnt = 0;
   int          exp_addr = 0;
   int          done_cnt = 0;
   int          cyc = 0;
   int          first_rd_cyc = 0;
   int          done_cyc = 0;
   logic        prev_stall = 1'b0;
   logic [7:0]  prev_data = 8'h0;
   logic        prev_rd = 1'b0;
   logic        prev_done = 1'b0;

   data_memory_dump_unit_if #(.NB_ADDR(5), .NB_DATA(32)) bus ();

   data_memory_dump_unit #(.NB_ADDR(5), .NB_DATA(32)) dut (
      .i_clock (clk),
      .i_reset (rst),
      .i_start (start),
      .o_busy  (busy),
      .o_done  (done),
      .bus     (bus)
   );

   assign bus.i_tx_ready = ready_drv;
   assign bus.i_mem_data = mem_q;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // synchronous-read memory model
   always @(posedge clk) if (bus.o_mem_rd_enable) mem_q <= mem[bus.o_mem_rd_addr];

   always @(posedge clk) begin
      #1;
      if (mode == 0) ready_drv = 1'b1;
      else           ready_drv = ($urandom_range(0, 9) < 3);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // monitor: byte scoreboard, hold rules, read-port and done checks
   always @(negedge clk) begin
      if (!rst) begin
         if (prev_stall) begin
            chk("hold_valid", {31'b0, bus.o_tx_valid}, 32'd1);
            chk("hold_data", {24'b0, bus.o_tx_data}, {24'b0, prev_data});
         end
         if (bus.o_tx_valid && bus.i_tx_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_byte", {24'b0, bus.o_tx_data}, 32'hFFFF_FFFF);
            end else begin
               chk("tx_byte", {24'b0, bus.o_tx_data}, {24'b0, exp_q.pop_front()});
            end
            nacc++;
         end
         prev_stall = bus.o_tx_valid && !bus.i_tx_ready;
         prev_data  = bus.o_tx_data;
         if (bus.o_mem_rd_enable) begin
            chk("rd_single", {31'b0, prev_rd}, 32'd0);
            chk("rd_addr", {27'b0, bus.o_mem_rd_addr}, exp_addr);
            chk("rd_state", {30'b0, done, busy}, 32'd1);
            if (rd_cnt == 0) first_rd_cyc = cyc;
            rd_cnt++;
            exp_addr++;
         end
         prev_rd = bus.o_mem_rd_enable;
         if (done) begin
            chk("done_single", {31'b0, prev_done}, 32'd0);
            done_cnt++;
            done_cyc = cyc;
         end
         prev_done = done;
      end else begin
         prev_stall = 1'b0;
         prev_rd    = 1'b0;
         prev_done  = 1'b0;
      end
   end

   task automatic pulse_start();
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic prep_dump(input int mode_i);
      mode     = mode_i;
      rd_cnt   = 0;
      exp_addr = 0;
      done_cnt = 0;
      nacc     = 0;
      for (int w = 0; w < 32; w++) begin
         logic [7:0] lsb;
         lsb = w[7:0];
         exp_q.push_back(8'hA0);
         exp_q.push_back(8'hB0);
         exp_q.push_back(8'hC0);
         exp_q.push_back(lsb);
      end
   endtask

   task automatic run_dump(input int mode_i, input bit restart_mid, input bit check_timing);
      prep_dump(mode_i);
      pulse_start();
      if (restart_mid) begin
         for (int k = 0; k < 2000 && exp_addr < 11; k++) @(negedge clk);
         chk("reached_word10", (exp_addr >= 11) ? 32'd1 : 32'd0, 32'd1);
         pulse_start();
      end
      for (int k = 0; k < 5000 && done_cnt == 0; k++) begin
         @(negedge clk);
         #2;
      end
      repeat (4) @(negedge clk);
      #2;
      chk("done_count", done_cnt, 32'd1);
      chk("bytes_accepted", nacc, 32'd128);
      chk("queue_empty", exp_q.size(), 32'd0);
      chk("rd_count", rd_cnt, 32'd32);
      chk("idle_busy", {31'b0, busy}, 32'd0);
      if (check_timing) chk("done_latency", done_cyc - first_rd_cyc, 32'd192);
   endtask

   initial begin
      for (int i = 0; i < 32; i++) mem[i] = 32'hA0B0C000 + i;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_tx_valid", {31'b0, bus.o_tx_valid}, 32'd0);
      chk("rst_tx_data", {24'b0, bus.o_tx_data}, 32'd0);
      chk("rst_rd_en", {31'b0, bus.o_mem_rd_enable}, 32'd0);
      chk("rst_rd_addr", {27'b0, bus.o_mem_rd_addr}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
      rst = 1'b0;

      run_dump(0, 1'b0, 1'b1);
      run_dump(1, 1'b0, 1'b0);
      run_dump(0, 1'b1, 1'b1);

      // abort during word 5, byte 2 (byte index 22 presented and popped)
      prep_dump(0);
      pulse_start();
      for (int k = 0; k < 2000 && nacc < 23; k++) begin
         @(negedge clk);
         #1;
      end
      chk("reached_w5b2", nacc, 32'd23);
      rst = 1'b1;
      #1;
      chk("abort_tx_valid", {31'b0, bus.o_tx_valid}, 32'd0);
      chk("abort_busy", {31'b0, busy}, 32'd0);
      chk("abort_rd_en", {31'b0, bus.o_mem_rd_enable}, 32'd0);
      chk("abort_done", {31'b0, done}, 32'd0);
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      run_dump(0, 1'b0, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
